// File: rtl/cmp_sequencer.sv
// Initiator for the registered compare unit: accepts one command at a time, issues a
// single compare request, checks the returned code and holds a decoded response until taken.
module cmp_sequencer #(
    parameter int width   = 16,
    parameter int TIMEOUT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [width-1:0] cmd_a,
    input  logic [width-1:0] cmd_b,
    input  logic [1:0]       cmd_op,
    output logic [width-1:0] A,
    output logic [width-1:0] B,
    output logic [1:0]       ALU_FUN,
    output logic             cmp_enable,
    input  logic [1:0]       cmp_out,
    input  logic             cmp_flag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [1:0]       rsp_code,
    output logic             rsp_true,
    output logic             rsp_err,
    output logic             busy
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            state, next_state;
    logic [CW-1:0]     cnt, next_cnt;
    logic [width-1:0]  next_a, next_b;
    logic [1:0]        next_fun, next_code;
    logic              next_true, next_err;

    // Next-state and next-output decode; every output is registered from these values.
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        next_a     = A;
        next_b     = B;
        next_fun   = ALU_FUN;
        next_code  = rsp_code;
        next_true  = rsp_true;
        next_err   = rsp_err;
        unique case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    if (cmd_op == 2'b00) begin
                        next_state = RESP;
                        next_code  = 2'b00;
                        next_true  = 1'b0;
                        next_err   = 1'b1;
                    end else begin
                        next_state = ISSUE;
                        next_a     = cmd_a;
                        next_b     = cmd_b;
                        next_fun   = cmd_op;
                    end
                end
            end
            ISSUE: begin
                next_state = WAIT;
                next_cnt   = '0;
            end
            WAIT: begin
                // The expected result code equals the op encoding (01, 10, 11).
                if (cmp_flag) begin
                    next_state = RESP;
                    next_code  = cmp_out;
                    next_true  = (cmp_out == ALU_FUN);
                    next_err   = (cmp_out != 2'b00) && (cmp_out != ALU_FUN);
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    next_state = RESP;
                    next_code  = 2'b00;
                    next_true  = 1'b0;
                    next_err   = 1'b1;
                end else begin
                    next_cnt = cnt + 1'b1;
                end
            end
            RESP: begin
                if (rsp_valid && rsp_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // State and output registers; handshake outputs follow directly from the next state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            cmd_ready  <= 1'b0;
            cmp_enable <= 1'b0;
            rsp_valid  <= 1'b0;
            busy       <= 1'b0;
            A          <= '0;
            B          <= '0;
            ALU_FUN    <= 2'b00;
            rsp_code   <= 2'b00;
            rsp_true   <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            state      <= next_state;
            cnt        <= next_cnt;
            cmd_ready  <= (next_state == IDLE);
            cmp_enable <= (next_state == ISSUE);
            rsp_valid  <= (next_state == RESP);
            busy       <= (next_state != IDLE);
            A          <= next_a;
            B          <= next_b;
            ALU_FUN    <= next_fun;
            rsp_code   <= next_code;
            rsp_true   <= next_true;
            rsp_err    <= next_err;
        end
    end

endmodule

// File: doc/cmp_sequencer.md
Name: cmp_sequencer

Overview:
Initiator side of the compare interface. Accepts compare commands over a valid/ready port and drives A, B, ALU_FUN and cmp_enable toward the registered compare unit. It captures the returned cmp_out/cmp_flag, checks the result, and presents a decoded response over a second valid/ready port. One command is in flight at a time. It sits between the control FSM / register file and the compare unit.

Parameters:
width, 16, operand width; must match the compare unit operand width.
TIMEOUT, 4, maximum WAIT cycles for cmp_flag before an error response is issued; minimum 1.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  synchronous active-low reset.
cmd_valid  input  1  command present.
cmd_ready  output  1  sequencer can accept a command.
cmd_a  input  width  operand A.
cmd_b  input  width  operand B.
cmd_op  input  2  01 = equal, 10 = greater, 11 = less, 00 = illegal.
A  output  width  operand A to the compare unit.
B  output  width  operand B to the compare unit.
ALU_FUN  output  2  operation to the compare unit.
cmp_enable  output  1  one-cycle compare request.
cmp_out  input  2  registered compare result code.
cmp_flag  input  1  result-valid from the compare unit.
rsp_valid  output  1  response present.
rsp_ready  input  1  consumer accepts the response.
rsp_code  output  2  raw cmp_out as captured.
rsp_true  output  1  comparison held.
rsp_err  output  1  illegal op, timeout, or inconsistent code.
busy  output  1  high whenever state is not IDLE.

Behaviour:
- One clock, clk. Reset is synchronous and active-low: sampled on the rising clk edge when reset==0. Every output is registered.
- Reset values:
  - state = IDLE.
  - cmd_ready, cmp_enable, rsp_valid, rsp_true, rsp_err, busy = 0.
  - A, B, ALU_FUN, rsp_code = 0.
  - cmd_ready rises in the first cycle after reset is released.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid && cmd_ready, latch cmd_a, cmd_b, cmd_op and drop cmd_ready.
  - If cmd_op == 00, go to RESP with rsp_err=1, rsp_true=0, rsp_code=00. No cmp_enable pulse is issued.
  - Otherwise, go to ISSUE with A/B/ALU_FUN loaded.
- ISSUE:
  - Exactly one cycle, cmp_enable=1.
  - Next state is WAIT and the wait counter is cleared to 0.
- WAIT:
  - cmp_enable=0; A, B and ALU_FUN are held stable.
  - Expected code: op 01 gives 1, op 10 gives 2, op 11 gives 3.
  - If cmp_flag==1, capture rsp_code = cmp_out and go to RESP.
    - rsp_true = 1 when cmp_out equals the expected code.
    - rsp_err = 1 when cmp_out is nonzero and not equal to the expected code.
  - If cmp_flag==0, increment the counter. When the counter reaches TIMEOUT-1 with no flag, go to RESP with rsp_err=1, rsp_true=0, rsp_code=00.
  - Any cmp_flag outside WAIT is ignored.
- RESP:
  - rsp_valid = 1; rsp_code, rsp_true and rsp_err are held stable until rsp_ready.
  - On rsp_valid && rsp_ready, clear rsp_valid, go to IDLE, and set cmd_ready=1 in the next cycle.
- Latency, with a compliant compare unit and the accept edge at the end of cycle 0:
  - cycle 1: ISSUE, cmp_enable high.
  - cycle 2: WAIT, cmp_flag seen.
  - cycle 3: rsp_valid high.
  - With rsp_ready already high, cmd_ready is back at cycle 4, giving 4 cycles per command.
  - Illegal op: rsp_valid at cycle 1.
- cmd_ready is 0 outside IDLE; cmd_valid is ignored there.
- Reset mid-operation, in any state: the command is discarded, no response is produced, and all outputs take their reset values on that edge.
- Operand comparison is unsigned and done by the compare unit. The sequencer performs no arithmetic beyond the code check.

Test Plan:
1. Reset with reset=0 for 3 cycles -> all outputs 0. Release -> cmd_ready=1 in the next cycle.
2. op=01, A=B=0x1234, rsp_ready=1 -> cmp_enable high for exactly 1 cycle, ALU_FUN=01, rsp_valid at cycle 3, rsp_code=01, rsp_true=1, rsp_err=0.
3. op=10, A=0x0005, B=0x0009 -> rsp_code=00, rsp_true=0, rsp_err=0. Then op=11 with the same operands -> rsp_code=11, rsp_true=1.
4. op=00 -> no cmp_enable pulse; rsp_valid at cycle 1 with rsp_err=1, rsp_code=00.
5. op=10, A=0xFFFF, B=0x0000, rsp_ready held 0 for 5 cycles -> rsp_code=10, rsp_true=1 stable throughout, cmd_ready=0, concurrent cmd_valid ignored. rsp_ready=1 -> IDLE, and the next command is accepted.
6. Compare-unit model with cmp_flag stuck at 0, TIMEOUT=4 -> rsp_err=1 after 4 WAIT cycles. Then reset=0 asserted during WAIT of a new command -> no rsp_valid, and state returns to IDLE.
